// File: rtl/hazard_forward_scheduler_pkg.sv
// Shared forward-select encodings and widths for the ID-stage hazard controller.
// Imported by the operand comparator and the scheduler top.
package hazard_forward_scheduler_pkg;

   localparam int unsigned FWD_WIDTH = 2;

   typedef enum logic [FWD_WIDTH-1:0] {
      FWD_REGFILE  = 2'b00,
      FWD_EX_ALU   = 2'b01,
      FWD_MEM_ALU  = 2'b10,
      FWD_MEM_LOAD = 2'b11
   } fwd_sel_e;

   // A producer writing r0 is architecturally a no-op, so it must never match.
   function automatic logic is_real_write(input logic wr, input logic any_nonzero_dest);
      return wr & any_nonzero_dest;
   endfunction

endpackage

// File: rtl/hazard_forward_scheduler_forward_operand_select.sv
// Priority compare of one ID source register against the EX and MEM shadows.
// Produces a load-use hazard flag and the operand forward select.
module forward_operand_select
   import hazard_forward_scheduler_pkg::*;
#(
   parameter int unsigned REG_ADDR_WIDTH = 5
) (
   input  logic [REG_ADDR_WIDTH-1:0] src_i,
   input  logic                      used_i,
   input  logic                      ex_write_i,
   input  logic [REG_ADDR_WIDTH-1:0] ex_dest_i,
   input  logic                      ex_is_load_i,
   input  logic                      mem_write_i,
   input  logic [REG_ADDR_WIDTH-1:0] mem_dest_i,
   input  logic                      mem_is_load_i,
   output logic                      hazard_o,
   output logic [FWD_WIDTH-1:0]      fwd_o
);

   logic ex_match;
   logic mem_match;

   assign ex_match  = ex_write_i  && (ex_dest_i  == src_i);
   assign mem_match = mem_write_i && (mem_dest_i == src_i);

   // EX is checked first so the youngest producer shadows an older MEM match.
   always_comb begin
      hazard_o = 1'b0;
      fwd_o    = FWD_REGFILE;
      if (!used_i || (src_i == '0)) begin
         hazard_o = 1'b0;
         fwd_o    = FWD_REGFILE;
      end else if (ex_match && ex_is_load_i) begin
         hazard_o = 1'b1;
         fwd_o    = FWD_REGFILE;
      end else if (ex_match) begin
         fwd_o = FWD_EX_ALU;
      end else if (mem_match) begin
         fwd_o = mem_is_load_i ? FWD_MEM_LOAD : FWD_MEM_ALU;
      end
   end

endmodule

// File: rtl/hazard_forward_scheduler.sv
// ID-stage hazard controller: shadows the EX/MEM destinations, drives the
// operand forward selects, the load-use stall, and a saturating stall counter.
module hazard_forward_scheduler
   import hazard_forward_scheduler_pkg::*;
#(
   parameter int unsigned REG_ADDR_WIDTH = 5,
   parameter int unsigned COUNT_WIDTH    = 32
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic [REG_ADDR_WIDTH-1:0] idRs,
   input  logic [REG_ADDR_WIDTH-1:0] idRt,
   input  logic                      idUsesRs,
   input  logic                      idUsesRt,
   input  logic                      idWriteRegister,
   input  logic [REG_ADDR_WIDTH-1:0] idDestination,
   input  logic                      idIsLoad,
   input  logic                      memStall,
   output logic                      shouldStall,
   output logic [FWD_WIDTH-1:0]      registerRsForwardControl,
   output logic [FWD_WIDTH-1:0]      registerRtForwardControl,
   output logic [COUNT_WIDTH-1:0]    stallCycleCount
);

   logic                      ex_write_q,  ex_write_d;
   logic [REG_ADDR_WIDTH-1:0] ex_dest_q,   ex_dest_d;
   logic                      ex_load_q,   ex_load_d;
   logic                      mem_write_q, mem_write_d;
   logic [REG_ADDR_WIDTH-1:0] mem_dest_q,  mem_dest_d;
   logic                      mem_load_q,  mem_load_d;
   logic [COUNT_WIDTH-1:0]    count_q,     count_d;

   logic                      hazard_rs;
   logic                      hazard_rt;
   logic                      id_write_valid;

   forward_operand_select #(.REG_ADDR_WIDTH(REG_ADDR_WIDTH)) u_fwd_rs (
      .src_i         (idRs),
      .used_i        (idUsesRs),
      .ex_write_i    (ex_write_q),
      .ex_dest_i     (ex_dest_q),
      .ex_is_load_i  (ex_load_q),
      .mem_write_i   (mem_write_q),
      .mem_dest_i    (mem_dest_q),
      .mem_is_load_i (mem_load_q),
      .hazard_o      (hazard_rs),
      .fwd_o         (registerRsForwardControl)
   );

   forward_operand_select #(.REG_ADDR_WIDTH(REG_ADDR_WIDTH)) u_fwd_rt (
      .src_i         (idRt),
      .used_i        (idUsesRt),
      .ex_write_i    (ex_write_q),
      .ex_dest_i     (ex_dest_q),
      .ex_is_load_i  (ex_load_q),
      .mem_write_i   (mem_write_q),
      .mem_dest_i    (mem_dest_q),
      .mem_is_load_i (mem_load_q),
      .hazard_o      (hazard_rt),
      .fwd_o         (registerRtForwardControl)
   );

   assign shouldStall     = hazard_rs | hazard_rt;
   assign stallCycleCount = count_q;
   assign id_write_valid  = is_real_write(idWriteRegister, |idDestination);

   always_comb begin
      ex_write_d  = ex_write_q;
      ex_dest_d   = ex_dest_q;
      ex_load_d   = ex_load_q;
      mem_write_d = mem_write_q;
      mem_dest_d  = mem_dest_q;
      mem_load_d  = mem_load_q;
      count_d     = count_q;
      // memStall freezes everything, even when a load-use hazard is pending.
      if (!memStall) begin
         mem_write_d = ex_write_q;
         mem_dest_d  = ex_dest_q;
         mem_load_d  = ex_load_q;
         if (shouldStall) begin
            ex_write_d = 1'b0;
            ex_dest_d  = '0;
            ex_load_d  = 1'b0;
            if (count_q != {COUNT_WIDTH{1'b1}}) begin
               count_d = count_q + 1'b1;
            end
         end else begin
            ex_write_d = id_write_valid;
            ex_dest_d  = idDestination;
            ex_load_d  = idIsLoad & id_write_valid;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         ex_write_q  <= 1'b0;
         ex_dest_q   <= '0;
         ex_load_q   <= 1'b0;
         mem_write_q <= 1'b0;
         mem_dest_q  <= '0;
         mem_load_q  <= 1'b0;
         count_q     <= '0;
      end else begin
         ex_write_q  <= ex_write_d;
         ex_dest_q   <= ex_dest_d;
         ex_load_q   <= ex_load_d;
         mem_write_q <= mem_write_d;
         mem_dest_q  <= mem_dest_d;
         mem_load_q  <= mem_load_d;
         count_q     <= count_d;
      end
   end

endmodule

// File: tb/tb_hazard_forward_scheduler.sv
// Directed MIPS hazard sequences followed by random traffic, all checked
// against an in-flight instruction list model.
module tb_hazard_forward_scheduler;

   localparam int CW = 4;

   logic          clock = 1'b0;
   logic          reset;
   logic [4:0]    idRs, idRt, idDestination;
   logic          idUsesRs, idUsesRt, idWriteRegister, idIsLoad, memStall;
   logic          shouldStall;
   logic [1:0]    fwdA, fwdB;
   logic [CW-1:0] stallCycleCount;

   int total = 0;
   int bad   = 0;

   hazard_forward_scheduler #(.REG_ADDR_WIDTH(5), .COUNT_WIDTH(CW)) dut (
      .clock                    (clock),
      .reset                    (reset),
      .idRs                     (idRs),
      .idRt                     (idRt),
      .idUsesRs                 (idUsesRs),
      .idUsesRt                 (idUsesRt),
      .idWriteRegister          (idWriteRegister),
      .idDestination            (idDestination),
      .idIsLoad                 (idIsLoad),
      .memStall                 (memStall),
      .shouldStall              (shouldStall),
      .registerRsForwardControl (fwdA),
      .registerRtForwardControl (fwdB),
      .stallCycleCount          (stallCycleCount)
   );

   always #5 clock = ~clock;

   // In-flight producers, index 0 = youngest (EX), index 1 = MEM.
   typedef struct {
      bit       writes;
      bit [4:0] dest;
      bit       load;
   } producer_t;

   producer_t flight[2];
   int        cnt_m;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic ins(input int rs, input int rt, input bit urs, input bit urt,
                      input bit wr, input int dst, input bit ld);
      idRs = 5'(rs); idRt = 5'(rt); idUsesRs = urs; idUsesRt = urt;
      idWriteRegister = wr; idDestination = 5'(dst); idIsLoad = ld;
      #1;
   endtask

   task automatic nop();
      ins(0, 0, 0, 0, 0, 0, 0);
   endtask

   // Youngest matching producer decides; a load there means the value is not ready.
   function automatic void resolve(input bit [4:0] src, input bit used,
                                   output bit haz, output bit [1:0] sel);
      haz = 0;
      sel = 2'b00;
      if (used && src != 0) begin
         for (int i = 0; i < 2; i++) begin
            if (flight[i].writes && flight[i].dest == src) begin
               if (i == 0) begin
                  haz = flight[i].load;
                  sel = flight[i].load ? 2'b00 : 2'b01;
               end else begin
                  sel = flight[i].load ? 2'b11 : 2'b10;
               end
               break;
            end
         end
      end
   endfunction

   task automatic tick();
      bit hz_a, hz_b;
      bit [1:0] sa, sb;
      bit st;
      resolve(idRs, idUsesRs, hz_a, sa);
      resolve(idRt, idUsesRt, hz_b, sb);
      st = hz_a | hz_b;
      chk("model_stall", {31'd0, shouldStall}, {31'd0, st});
      chk("model_fwdA", {30'd0, fwdA}, {30'd0, sa});
      chk("model_fwdB", {30'd0, fwdB}, {30'd0, sb});
      chk("model_count", {28'd0, stallCycleCount}, cnt_m);
      @(posedge clock);
      if (reset) begin
         flight[0] = '{0, 0, 0};
         flight[1] = '{0, 0, 0};
         cnt_m = 0;
      end else if (!memStall) begin
         flight[1] = flight[0];
         if (st) begin
            flight[0] = '{0, 0, 0};
            if (cnt_m < (1 << CW) - 1) cnt_m++;
         end else begin
            flight[0].writes = idWriteRegister && idDestination != 0;
            flight[0].dest   = idDestination;
            flight[0].load   = idIsLoad && idWriteRegister && idDestination != 0;
         end
      end
      @(negedge clock);
   endtask

   initial begin
      flight[0] = '{0, 0, 0};
      flight[1] = '{0, 0, 0};
      cnt_m = 0;
      reset = 1; memStall = 0;
      nop();
      @(negedge clock);
      tick(); tick();
      reset = 0;
      nop();
      chk("reset_stall", {31'd0, shouldStall}, 0);
      chk("reset_fwd", {28'd0, fwdA, fwdB}, 0);
      chk("reset_count", {28'd0, stallCycleCount}, 0);
      tick();

      // add r3,r1,r2 ; sub r4,r3,r5
      ins(1, 2, 1, 1, 1, 3, 0); tick();
      ins(3, 5, 1, 1, 1, 4, 0);
      chk("alu_fwdA", {30'd0, fwdA}, 1);
      chk("alu_fwdB", {30'd0, fwdB}, 0);
      chk("alu_stall", {31'd0, shouldStall}, 0);
      tick(); nop(); tick(); tick();

      // lw r3,0(r1) ; add r4,r2,r3
      ins(1, 0, 1, 0, 1, 3, 1); tick();
      ins(2, 3, 1, 1, 1, 4, 0);
      chk("lu_stall1", {31'd0, shouldStall}, 1);
      chk("lu_fwdB1", {30'd0, fwdB}, 0);
      tick();
      chk("lu_stall2", {31'd0, shouldStall}, 0);
      chk("lu_fwdB2", {30'd0, fwdB}, 3);
      tick();
      chk("lu_count", {28'd0, stallCycleCount}, 1);
      nop(); tick(); tick();

      // add r3 ; or r6 ; and r7,r3,r3
      ins(1, 2, 1, 1, 1, 3, 0); tick();
      ins(1, 2, 1, 1, 1, 6, 0); tick();
      ins(3, 3, 1, 1, 1, 7, 0);
      chk("mem_fwdA", {30'd0, fwdA}, 2);
      chk("mem_fwdB", {30'd0, fwdB}, 2);
      tick(); nop(); tick(); tick();

      // add r3 ; add r3 ; xor r8,r3,r0
      ins(1, 2, 1, 1, 1, 3, 0); tick();
      ins(4, 5, 1, 1, 1, 3, 0); tick();
      ins(3, 0, 1, 1, 1, 8, 0);
      chk("young_fwdA", {30'd0, fwdA}, 1);
      chk("young_fwdB", {30'd0, fwdB}, 0);
      tick(); nop(); tick(); tick();

      // addi r0,r1,5 then read r0
      ins(1, 0, 1, 0, 1, 0, 0); tick();
      ins(0, 0, 1, 1, 1, 9, 0);
      chk("r0_fwd", {28'd0, fwdA, fwdB}, 0);
      chk("r0_stall", {31'd0, shouldStall}, 0);
      tick(); nop(); tick(); tick();

      // lw r3 ; beq r3,r3
      ins(1, 0, 1, 0, 1, 3, 1); tick();
      ins(3, 3, 1, 1, 0, 0, 0);
      chk("beq_stall1", {31'd0, shouldStall}, 1);
      tick();
      chk("beq_stall2", {31'd0, shouldStall}, 0);
      chk("beq_fwd", {28'd0, fwdA, fwdB}, 4'hF);
      tick(); nop(); tick(); tick();

      // load-use frozen by memStall for three cycles
      ins(1, 0, 1, 0, 1, 3, 1); tick();
      ins(2, 3, 1, 1, 1, 4, 0);
      memStall = 1;
      for (int i = 0; i < 3; i++) begin
         chk("ms_stall", {31'd0, shouldStall}, 1);
         tick();
      end
      chk("ms_count_frozen", {28'd0, stallCycleCount}, 2);
      memStall = 0;
      tick();
      chk("ms_release_fwdB", {30'd0, fwdB}, 3);
      tick();
      chk("ms_count", {28'd0, stallCycleCount}, 3);
      nop(); tick(); tick();

      // drive the counter into saturation
      for (int i = 0; i < 15; i++) begin
         ins(1, 0, 1, 0, 1, 3, 1); tick();
         ins(2, 3, 1, 1, 1, 4, 0); tick(); tick();
      end
      chk("sat_count", {28'd0, stallCycleCount}, 15);
      nop(); tick(); tick();

      // reset asserted while a load-use stall is pending
      ins(1, 0, 1, 0, 1, 3, 1); tick();
      ins(2, 3, 1, 1, 1, 4, 0);
      chk("rst_pre_stall", {31'd0, shouldStall}, 1);
      reset = 1;
      tick();
      reset = 0;
      #1;
      chk("rst_stall", {31'd0, shouldStall}, 0);
      chk("rst_fwd", {28'd0, fwdA, fwdB}, 0);
      chk("rst_count", {28'd0, stallCycleCount}, 0);
      tick();

      // random traffic over a small register set to force collisions
      for (int n = 0; n < 400; n++) begin
         bit wr, ld;
         wr = 1'($urandom_range(0, 3) != 0);
         ld = wr & 1'($urandom_range(0, 2) == 0);
         memStall = ($urandom_range(0, 7) == 0);
         reset    = ($urandom_range(0, 59) == 0);
         ins($urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom), 1'($urandom),
             wr, $urandom_range(0, 3), ld);
         tick();
      end
      reset = 0; memStall = 0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
